// File: rtl/number_packer_if.sv
// Handshake bundle between a one-number-per-beat producer, the packer and the pipeline adder.
// sum_o is present only when NUMBER_PACKER_SUM_EN is defined.
interface number_packer_if #(
  parameter int unsigned NUMBERS_AMOUNT = 8,
  parameter int unsigned NUMBER_WIDTH   = 4
);
  localparam int unsigned SumWidth = NUMBER_WIDTH + $clog2(NUMBERS_AMOUNT);

  logic [NUMBER_WIDTH-1:0]                     data_i;
  logic                                        data_valid_i;
  logic                                        ready_o;
  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_o;
  logic                                        data_valid_o;
  logic                                        ready_i;
`ifdef NUMBER_PACKER_SUM_EN
  logic [SumWidth-1:0]                         sum_o;
`endif

  // slave: the packer itself; master: the surrounding producer/consumer.
  modport slave (
    input  data_i,
    input  data_valid_i,
    input  ready_i,
    output ready_o,
    output data_o,
    output data_valid_o
`ifdef NUMBER_PACKER_SUM_EN
    ,
    output sum_o
`endif
  );

  modport master (
    output data_i,
    output data_valid_i,
    output ready_i,
    input  ready_o,
    input  data_o,
    input  data_valid_o
`ifdef NUMBER_PACKER_SUM_EN
    ,
    input  sum_o
`endif
  );
endinterface

// File: rtl/number_packer.sv
// Collects NUMBERS_AMOUNT serial operands into one packed vector for the pipeline adder.
// Defining NUMBER_PACKER_SUM_EN adds a registered exact running sum on sum_o.
module number_packer #(
  parameter int unsigned NUMBERS_AMOUNT = 8,
  parameter int unsigned NUMBER_WIDTH   = 4,
  parameter bit          SIGNED         = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  number_packer_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(NUMBERS_AMOUNT);

  if (NUMBERS_AMOUNT < 2 || NUMBER_WIDTH < 1 || SIGNED > 1'b1) begin : g_param_check
    $error("number_packer: illegal parameter combination");
  end

  typedef enum logic {StFill, StFull} state_e;

  state_e                                      state_q, state_d;
  logic [IdxW-1:0]                             idx_q, idx_d;
  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_q, data_d;
  logic                                        in_hs, out_hs;

  // ready_i feeds ready_o combinationally so a full vector can drain while the next fills.
  assign bus.ready_o      = (state_q == StFill) || bus.ready_i;
  assign bus.data_valid_o = (state_q == StFull);
  assign bus.data_o       = data_q;
  assign in_hs            = bus.data_valid_i && bus.ready_o;
  assign out_hs           = bus.data_valid_o && bus.ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      StFill: begin
        if (in_hs) begin
          data_d[idx_q] = bus.data_i;
          if (idx_q == IdxW'(NUMBERS_AMOUNT - 1)) begin
            idx_d   = '0;
            state_d = StFull;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StFull: begin
        if (out_hs) begin
          state_d = StFill;
          if (in_hs) begin
            data_d[0] = bus.data_i;
            idx_d     = IdxW'(1);
          end else begin
            idx_d = '0;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StFill;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

`ifdef NUMBER_PACKER_SUM_EN
  localparam int unsigned SumW = NUMBER_WIDTH + $clog2(NUMBERS_AMOUNT);
  localparam int unsigned ExtW = SumW - NUMBER_WIDTH;

  logic [SumW-1:0] sum_q, sum_d, operand_ext;

  assign operand_ext = SIGNED ? {{ExtW{bus.data_i[NUMBER_WIDTH-1]}}, bus.data_i}
                              : {{ExtW{1'b0}}, bus.data_i};
  assign bus.sum_o   = sum_q;

  // The first operand of a vector loads the accumulator, later ones add to it.
  always_comb begin
    sum_d = sum_q;
    if (in_hs) begin
      if (state_q == StFull || idx_q == '0) begin
        sum_d = operand_ext;
      end else begin
        sum_d = sum_q + operand_ext;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif
endmodule

// File: tb/tb_number_packer.sv
// Randomized scoreboard bench for number_packer; sum checks are active with NUMBER_PACKER_SUM_EN.
module tb_number_packer;
  localparam int unsigned N      = 8;
  localparam int unsigned W      = 4;
  localparam bit          SIGNED = 1'b1;
  localparam int unsigned SumW   = W + $clog2(N);

  typedef struct {
    logic [N*W-1:0]  vec;
    logic [SumW-1:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  number_packer_if #(.NUMBERS_AMOUNT(N), .NUMBER_WIDTH(W)) bus ();

  number_packer #(.NUMBERS_AMOUNT(N), .NUMBER_WIDTH(W), .SIGNED(SIGNED)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  exp_t           exp_q[$];
  logic [W-1:0]   cur[$];
  bit             mdl_full;
  int             total = 0;
  int             bad   = 0;
  int             pops  = 0;
  bit             hold;
  logic [N*W-1:0] hold_data;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  // Reference: an operand is accepted unless a finished vector is waiting on a stalled consumer.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r);
    bit   acc;
    exp_t e;
    int   s;
    int   val;
    bus.data_valid_i = v;
    bus.data_i       = d;
    bus.ready_i      = r;
    @(negedge clk);
    chk("data_valid_o", {63'd0, bus.data_valid_o}, {63'd0, mdl_full});
    chk("ready_o", {63'd0, bus.ready_o}, {63'd0, (!mdl_full || r)});
    acc = v && (!mdl_full || r);
    if (mdl_full && r) mdl_full = 1'b0;
    if (acc) begin
      cur.push_back(d);
      if (cur.size() == N) begin
        s = 0;
        for (int i = 0; i < N; i++) begin
          e.vec[i*W +: W] = cur[i];
          val = int'(cur[i]);
          if (SIGNED && cur[i][W-1]) val = val - (1 << W);
          s = s + val;
        end
        e.sum = s[SumW-1:0];
        exp_q.push_back(e);
        cur.delete();
        mdl_full = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ready_i      = 1'b0;
    bus.data_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("rst_data_valid_o", {63'd0, bus.data_valid_o}, 64'd0);
    chk("rst_data_o", {32'd0, bus.data_o}, 64'd0);
    chk("rst_ready_o", {63'd0, bus.ready_o}, 64'd1);
`ifdef NUMBER_PACKER_SUM_EN
    chk("rst_sum_o", {57'd0, bus.sum_o}, 64'd0);
`endif
    exp_q.delete();
    cur.delete();
    mdl_full = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      if (hold && bus.data_valid_o) chk("hold_stable", {32'd0, bus.data_o}, {32'd0, hold_data});
      if (bus.data_valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vector: got=%0h required=none", bus.data_o);
        end else begin
          e = exp_q.pop_front();
          chk("vector", {32'd0, bus.data_o}, {32'd0, e.vec});
`ifdef NUMBER_PACKER_SUM_EN
          chk("sum_o", {57'd0, bus.sum_o}, {57'd0, e.sum});
`endif
          pops++;
        end
      end
      hold      = bus.data_valid_o && !bus.ready_i;
      hold_data = bus.data_o;
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    int p0;
    rst_i            = 1'b0;
    bus.data_i       = '0;
    bus.data_valid_i = 1'b0;
    bus.ready_i      = 1'b0;
    mdl_full         = 1'b0;
    hold             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_data_valid_o", {63'd0, bus.data_valid_o}, 64'd0);
    chk("init_data_o", {32'd0, bus.data_o}, 64'd0);
    chk("init_ready_o", {63'd0, bus.ready_o}, 64'd1);
`ifdef NUMBER_PACKER_SUM_EN
    chk("init_sum_o", {57'd0, bus.sum_o}, 64'd0);
`endif
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;

    // Ascending fill while the consumer stalls.
    p0 = pops;
    for (int i = 0; i < N; i++) cycle(1'b1, W'(i), 1'b0);
    repeat (3) cycle(1'b1, 4'hf, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("fill_vectors", 64'(pops - p0), 64'd1);

    // Signed extremes.
    for (int i = 0; i < N; i++) cycle(1'b1, 4'h8, 1'b0);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < N; i++) cycle(1'b1, 4'h7, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Back-to-back streaming with the consumer always ready.
    p0 = pops;
    for (int i = 0; i < 3 * N; i++) cycle(1'b1, W'($urandom), 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("b2b_vectors", 64'(pops - p0), 64'd3);

    // Reset after five accepted operands, then a fresh vector.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'($urandom), 1'b0);
    do_reset();
    p0 = pops;
    for (int i = 0; i < N; i++) cycle(1'b1, W'(i + 3), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("post_reset_fill_vectors", 64'(pops - p0), 64'd1);

    // Reset while a vector is pending.
    for (int i = 0; i < N; i++) cycle(1'b1, W'($urandom), 1'b0);
    cycle(1'b0, '0, 1'b0);
    do_reset();
    p0 = pops;
    for (int i = 0; i < N; i++) cycle(1'b1, W'($urandom), 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("post_reset_full_vectors", 64'(pops - p0), 64'd1);

    // Random backpressure on both sides.
    for (int i = 0; i < 1000; i++) begin
      cycle(($urandom % 4) != 0, W'($urandom), ($urandom % 2) != 0);
    end
    repeat (2) cycle(1'b0, '0, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
